// File: rtl/axis_i2s_transmitter.sv
// AXI-Stream to I2S transmitter: buffers one left/right pair and serialises it
// into 64-SCLK I2S frames. The pair is loaded into the shift registers at the frame boundary.
//
// state  | meaning
// FILL_L | waiting for a left beat (last=0)
// FILL_R | left held, waiting for the right beat (last=1)
// FULL   | complete pair held until the next frame load
module axis_i2s_transmitter #(
    parameter int DATA_WIDTH  = 32,
    parameter int AUDIO_WIDTH = 24,
    parameter int SCLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic                  i2s_sclk,
    output logic                  i2s_lrck,
    output logic                  i2s_sdata,
    output logic                  underrun,
    output logic                  sync_err
);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    typedef enum logic [1:0] {
        FILL_L,
        FILL_R,
        FULL
    } buf_state_t;

    buf_state_t             state;
    logic [DIV_W-1:0]       div_cnt;
    logic [5:0]             bit_cnt;
    logic [AUDIO_WIDTH-1:0] smp_l;
    logic [AUDIO_WIDTH-1:0] smp_r;
    logic [AUDIO_WIDTH-1:0] shift_l;
    logic [AUDIO_WIDTH-1:0] shift_r;

    logic                   div_wrap;
    logic                   sclk_fall;
    logic                   frame_load;
    logic                   beat_ok;
    logic                   data_slot;
    logic [5:0]             bit_next;
    logic [4:0]             slot_next;
    logic [AUDIO_WIDTH-1:0] beat_smp;

    assign s_axis_ready = (state != FULL) && !rst;
    assign beat_ok      = s_axis_valid && s_axis_ready;
    assign beat_smp     = s_axis_data[AUDIO_WIDTH-1:0];
    assign div_wrap     = (div_cnt == DIV_LAST);
    assign sclk_fall    = div_wrap && i2s_sclk;
    assign bit_next     = bit_cnt + 6'd1;
    assign frame_load   = sclk_fall && (bit_cnt == 6'd63);
    assign slot_next    = bit_next[4:0];
    // Slot 0 of each channel is the one-SCLK I2S delay; slots past the sample are padding
    assign data_slot    = (slot_next != 5'd0) && (int'(slot_next) <= AUDIO_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL_L;
            div_cnt   <= '0;
            bit_cnt   <= 6'd63;
            i2s_sclk  <= 1'b0;
            i2s_lrck  <= 1'b1;
            i2s_sdata <= 1'b0;
            underrun  <= 1'b0;
            sync_err  <= 1'b0;
            smp_l     <= '0;
            smp_r     <= '0;
            shift_l   <= '0;
            shift_r   <= '0;
        end else begin
            underrun <= 1'b0;
            sync_err <= 1'b0;
            div_cnt  <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap) begin
                i2s_sclk <= !i2s_sclk;
            end

            if (sclk_fall) begin
                bit_cnt  <= bit_next;
                i2s_lrck <= bit_next[5];
                if (frame_load) begin
                    i2s_sdata <= 1'b0;
                    if (state == FULL) begin
                        shift_l <= smp_l;
                        shift_r <= smp_r;
                    end else begin
                        shift_l  <= '0;
                        shift_r  <= '0;
                        underrun <= 1'b1;
                    end
                end else if (data_slot) begin
                    if (bit_next[5]) begin
                        i2s_sdata <= shift_r[AUDIO_WIDTH-1];
                        shift_r   <= shift_r << 1;
                    end else begin
                        i2s_sdata <= shift_l[AUDIO_WIDTH-1];
                        shift_l   <= shift_l << 1;
                    end
                end else begin
                    i2s_sdata <= 1'b0;
                end
            end

            // A right beat landing on the load cycle is not yet FULL, so that frame underruns
            if (frame_load && (state == FULL)) begin
                state <= FILL_L;
            end else if (beat_ok) begin
                case (state)
                    FILL_L: begin
                        if (s_axis_last) begin
                            sync_err <= 1'b1;
                        end else begin
                            smp_l <= beat_smp;
                            state <= FILL_R;
                        end
                    end
                    FILL_R: begin
                        if (s_axis_last) begin
                            smp_r <= beat_smp;
                            state <= FULL;
                        end else begin
                            smp_l    <= beat_smp;
                            sync_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axis_i2s_transmitter.sv
// Directed bench for axis_i2s_transmitter: decodes the I2S stream into 32-bit
// channel words and compares them with hand-computed frames.
module tb_axis_i2s_transmitter;
    localparam int DW  = 32;
    localparam int AW  = 24;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_data = '0;
    logic          s_axis_valid = 1'b0;
    logic          s_axis_ready;
    logic          s_axis_last = 1'b0;
    logic          i2s_sclk;
    logic          i2s_lrck;
    logic          i2s_sdata;
    logic          underrun;
    logic          sync_err;

    axis_i2s_transmitter #(
        .DATA_WIDTH (DW),
        .AUDIO_WIDTH(AW),
        .SCLK_DIV   (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axis_data (s_axis_data),
        .s_axis_valid(s_axis_valid),
        .s_axis_ready(s_axis_ready),
        .s_axis_last (s_axis_last),
        .i2s_sclk    (i2s_sclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_sdata   (i2s_sdata),
        .underrun    (underrun),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor
    int          ur_cnt;
    int          se_cnt;
    int          sclk_period;
    int          last_rise;
    int          l_cnt;
    int          r_cnt;
    logic        prev_sclk;
    logic        prev_lrck;
    logic        prev_lr_bit;
    logic [31:0] lw;
    logic [31:0] rw;
    logic [63:0] frames[$];
    int          falls[$];

    always @(negedge clk) begin
        if (rst) begin
            ur_cnt      <= 0;
            se_cnt      <= 0;
            sclk_period <= 0;
            last_rise   <= 0;
            l_cnt       <= 0;
            r_cnt       <= 0;
            prev_sclk   <= 1'b0;
            prev_lrck   <= 1'b1;
            prev_lr_bit <= 1'b1;
            lw          <= '0;
            rw          <= '0;
            frames.delete();
            falls.delete();
        end else begin
            if (underrun) ur_cnt <= ur_cnt + 1;
            if (sync_err) se_cnt <= se_cnt + 1;
            if (prev_lrck && !i2s_lrck) falls.push_back(cyc);
            if (i2s_sclk && !prev_sclk) begin
                sclk_period <= cyc - last_rise;
                last_rise   <= cyc;
                prev_lr_bit <= i2s_lrck;
                if (!i2s_lrck) begin
                    if (prev_lr_bit) begin
                        if (l_cnt == 32 && r_cnt == 32) frames.push_back({lw, rw});
                        lw    <= {31'd0, i2s_sdata};
                        rw    <= '0;
                        l_cnt <= 1;
                        r_cnt <= 0;
                    end else begin
                        lw    <= {lw[30:0], i2s_sdata};
                        l_cnt <= l_cnt + 1;
                    end
                end else begin
                    rw    <= {rw[30:0], i2s_sdata};
                    r_cnt <= r_cnt + 1;
                end
            end
            prev_sclk <= i2s_sclk;
            prev_lrck <= i2s_lrck;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int t0      = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i2s_word(input logic [23:0] s);
        return {1'b0, s, 7'b0};
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        s_axis_data  = '0;
        repeat (3) step();
    endtask

    task automatic release_rst();
        rst = 1'b0;
        t0  = cyc;
        #1;
    endtask

    task automatic wait_until(input int c);
        int k = 0;
        while (cyc < c && k < 3000) begin
            step();
            k++;
        end
    endtask

    task automatic send_beat(input logic [31:0] d, input logic last);
        int k = 0;
        s_axis_data  = d;
        s_axis_last  = last;
        s_axis_valid = 1'b1;
        while (!s_axis_ready && k < 2000) begin
            step();
            k++;
        end
        if (k >= 2000) check_eq("beat_timeout", s_axis_ready, 1'b1);
        step();
        s_axis_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (frames.size() < n && k < 3000) begin
            step();
            k++;
        end
        if (frames.size() < n) check_eq("frame_timeout", frames.size(), n);
    endtask

    task automatic wait_falls(input int n);
        int k = 0;
        while (falls.size() < n && k < 3000) begin
            step();
            k++;
        end
        if (falls.size() < n) check_eq("lrck_fall_timeout", falls.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx;
        logic rdy_prev;
        int   k;

        // Reset values
        do_reset();
        check_eq("rst_sclk", i2s_sclk, 1'b0);
        check_eq("rst_lrck", i2s_lrck, 1'b1);
        check_eq("rst_sdata", i2s_sdata, 1'b0);
        check_eq("rst_underrun", underrun, 1'b0);
        check_eq("rst_sync_err", sync_err, 1'b0);
        check_eq("rst_ready", s_axis_ready, 1'b0);

        // Idle timing: no data, every frame underruns and sends zeros
        release_rst();
        wait_falls(2);
        check_eq("first_lrck_fall", falls[0] - t0, 8);
        check_eq("lrck_period", falls[1] - falls[0], 512);
        check_eq("sclk_period", sclk_period, 8);
        check_eq("idle_underruns", ur_cnt, 2);
        wait_frames(1);
        check_eq("idle_frame", frames[0], 64'd0);

        // One pair loaded before the first boundary
        do_reset();
        release_rst();
        send_beat(32'h00A5A5A5, 1'b0);
        send_beat(32'h00123456, 1'b1);
        check_eq("ready_full", s_axis_ready, 1'b0);
        wait_until(t0 + 7);
        check_eq("ready_before_load", s_axis_ready, 1'b0);
        wait_until(t0 + 8);
        check_eq("ready_after_load", s_axis_ready, 1'b1);
        check_eq("pair_no_underrun", ur_cnt, 0);
        wait_frames(1);
        check_eq("pair_left", frames[0][63:32], i2s_word(24'hA5A5A5));
        check_eq("pair_right", frames[0][31:0], i2s_word(24'h123456));

        // Channel sync errors
        do_reset();
        release_rst();
        send_beat(32'h00ABCDEF, 1'b1);
        send_beat(32'h00000001, 1'b0);
        send_beat(32'h00000002, 1'b0);
        send_beat(32'h00000003, 1'b1);
        wait_frames(1);
        check_eq("sync_err_count", se_cnt, 2);
        check_eq("sync_left", frames[0][63:32], i2s_word(24'h000002));
        check_eq("sync_right", frames[0][31:0], i2s_word(24'h000003));

        // Continuous valid: one pair per frame, upper data bits ignored
        do_reset();
        release_rst();
        idx          = 0;
        s_axis_valid = 1'b1;
        s_axis_data  = 32'hAB100000;
        s_axis_last  = 1'b0;
        rdy_prev     = s_axis_ready;
        k            = 0;
        while (frames.size() < 3 && k < 2500) begin
            step();
            k++;
            if (rdy_prev) idx++;
            s_axis_last = idx[0];
            s_axis_data = idx[0] ? (32'h00200000 + 32'(idx / 2)) : (32'hAB100000 + 32'(idx / 2));
            if (cyc == t0 + 300) begin
                check_eq("stream_ready_full", s_axis_ready, 1'b0);
                check_eq("stream_beats_frame0", idx, 4);
            end
            rdy_prev = s_axis_ready;
        end
        s_axis_valid = 1'b0;
        if (frames.size() < 3) check_eq("stream_timeout", frames.size(), 3);
        for (int f = 0; f < 3; f++) begin
            check_eq($sformatf("stream_left%0d", f), frames[f][63:32], i2s_word(24'h100000 + 24'(f)));
            check_eq($sformatf("stream_right%0d", f), frames[f][31:0], i2s_word(24'h200000 + 24'(f)));
        end
        check_eq("stream_no_underrun", ur_cnt, 0);

        // Right beat on the frame-load cycle
        do_reset();
        release_rst();
        send_beat(32'h00654321, 1'b0);
        wait_until(t0 + 7);
        s_axis_data  = 32'h00FEDCBA;
        s_axis_last  = 1'b1;
        s_axis_valid = 1'b1;
        step();
        s_axis_valid = 1'b0;
        check_eq("late_underrun", underrun, 1'b1);
        check_eq("late_ready_full", s_axis_ready, 1'b0);
        wait_frames(1);
        check_eq("late_underrun_count", ur_cnt, 1);
        check_eq("late_frame0", frames[0], 64'd0);
        wait_frames(2);
        check_eq("late_left", frames[1][63:32], i2s_word(24'h654321));
        check_eq("late_right", frames[1][31:0], i2s_word(24'hFEDCBA));

        // Reset in the middle of the right channel
        do_reset();
        release_rst();
        send_beat(32'h00FFFFFF, 1'b0);
        send_beat(32'h00FFFFFF, 1'b1);
        send_beat(32'h000F0F0F, 1'b0);
        send_beat(32'h000F0F0F, 1'b1);
        wait_until(t0 + 310);
        check_eq("pre_rst_sdata", i2s_sdata, 1'b1);
        check_eq("pre_rst_sclk", i2s_sclk, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_sclk", i2s_sclk, 1'b0);
        check_eq("mid_rst_lrck", i2s_lrck, 1'b1);
        check_eq("mid_rst_sdata", i2s_sdata, 1'b0);
        check_eq("mid_rst_ready", s_axis_ready, 1'b0);
        repeat (3) step();
        release_rst();
        wait_frames(1);
        check_eq("post_rst_frame", frames[0], 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
